// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide unit for the E stage: holds HI/LO, counts out the
// operation latency and raises the D/F stall while a D-stage md instruction would collide.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  md_op,
  input  logic        md_valid,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_ok_q, pend_ok_d;

  logic        is_mul, is_div, signed_op, start;
  logic [63:0] prod_s, prod_u, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_den, q_mag, r_mag, quot, rem;

  assign is_mul    = (md_op == OP_MULT) | (md_op == OP_MULTU);
  assign is_div    = (md_op == OP_DIV)  | (md_op == OP_DIVU);
  assign signed_op = (md_op == OP_MULT) | (md_op == OP_DIV);
  assign start     = md_valid & (is_mul | is_div) & (state_q == S_IDLE);

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};
  assign prod   = signed_op ? prod_s : prod_u;

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign neg_a   = signed_op & src_a[31];
  assign neg_b   = signed_op & src_b[31];
  assign mag_a   = neg_a ? (~src_a + 32'd1) : src_a;
  assign mag_b   = neg_b ? (~src_b + 32'd1) : src_b;
  assign div_den = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag   = mag_a / div_den;
  assign r_mag   = mag_a % div_den;
  assign quot    = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem     = neg_a ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_mul) begin
          pend_hi_d = prod[63:32];
          pend_lo_d = prod[31:0];
          pend_ok_d = 1'b1;
          cnt_d     = CW'(MULT_CYCLES - 1);
          state_d   = S_MUL;
        end else if (start) begin
          pend_hi_d = rem;
          pend_lo_d = quot;
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          pend_ok_d = (src_b != 32'd0);
          cnt_d     = CW'(DIV_CYCLES - 1);
          state_d   = S_DIV;
        end else if (md_valid && md_op == OP_MTHI) begin
          hi_d = src_a;
        end else if (md_valid && md_op == OP_MTLO) begin
          lo_d = src_a;
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = d_uses_md & (busy | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus pushes expected HI/LO and latency,
// a negedge monitor pops and compares whenever busy falls.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic        md_valid = 1'b0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        d_uses_md = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .md_op     (md_op),
    .md_valid  (md_valid),
    .src_a     (src_a),
    .src_b     (src_b),
    .d_uses_md (d_uses_md),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  // Monitor: completions are detected as busy falling while out of reset.
  initial begin
    logic busy_prev;
    int   busy_cnt;
    exp_t e;
    busy_prev = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_prev = 1'b0;
        busy_cnt  = 0;
      end else begin
        checks++;
        if (busy && md_valid && (md_op inside {[3'd1:3'd6]})) begin
          failures++;
          $display("FAIL op_while_busy: op=%0d presented with busy=1, required no op", md_op);
        end
        if (busy) begin
          busy_cnt++;
        end else if (busy_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_completion: got hi=%h lo=%h, required no completion", hi, lo);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_hi"}, hi, e.hi);
            chk({e.name, "_lo"}, lo, e.lo);
            chk({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.cycles));
            $display("txn %s hi=%h lo=%h busy_cycles=%0d", e.name, hi, lo, busy_cnt);
          end
          busy_cnt = 0;
        end
        busy_prev = busy;
      end
    end
  end

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic du, input logic [31:0] eh,
                       input logic [31:0] el, input int n);
    exp_t e;
    int waited;
    logic [31:0] old_hi, old_lo;
    e.hi = eh; e.lo = el; e.cycles = n; e.name = name;
    exp_q.push_back(e);
    @(posedge clk); #1;
    md_valid = 1'b1; md_op = op; src_a = a; src_b = b; d_uses_md = du;
    #1;
    old_hi = hi; old_lo = lo;
    chk({name, "_issue_stall"}, 32'(stall), 32'(du));
    chk({name, "_issue_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 3'd0; src_a = $urandom; src_b = $urandom;
    chk({name, "_busy_after_issue"}, 32'(busy), 32'd1);
    waited = 0;
    while (busy && waited < n + 5) begin
      chk({name, "_busy_stall"}, 32'(stall), 32'(du));
      chk({name, "_hold_hi"}, hi, old_hi);
      chk({name, "_hold_lo"}, lo, old_lo);
      @(posedge clk); #1;
      waited++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: busy=1 after %0d cycles, required 0", name, waited);
    end
    d_uses_md = 1'b1;
    #1;
    chk({name, "_post_commit_stall"}, 32'(stall), 32'd0);
    d_uses_md = 1'b0;
  endtask

  initial begin
    // Reset state
    d_uses_md = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    reset_n = 1'b1;
    d_uses_md = 1'b0;

    do_op("mult_m3x5",   3'b001, 32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    do_op("multu_max",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 5);
    do_op("div_m7_2",    3'b011, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    do_op("divu_7_2",    3'b100, 32'd7,        32'd2,        1'b0, 32'd1,        32'd3,        10);
    do_op("div_ovf",     3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000, 10);

    // mthi then mtlo on consecutive cycles
    @(posedge clk); #1;
    md_valid = 1'b1; md_op = 3'b101; src_a = 32'h12345678; d_uses_md = 1'b1;
    #1;
    chk("mthi_stall_idle", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo_kept", lo, 32'h80000000);
    chk("mthi_busy", 32'(busy), 32'd0);
    md_op = 3'b110; src_a = 32'h9ABCDEF0;
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 3'd0; d_uses_md = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_busy", 32'(busy), 32'd0);
    $display("txn mthi/mtlo hi=%h lo=%h", hi, lo);

    do_op("divu_by_zero", 3'b100, 32'd5, 32'd0, 1'b1, 32'h12345678, 32'h9ABCDEF0, 10);

    // Non-issuing inputs: bubble with an op code, and the 111 / 000 codes
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 3'b001; src_a = 32'd3; src_b = 32'd3; d_uses_md = 1'b1;
    #1;
    chk("bubble_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("bubble_busy", 32'(busy), 32'd0);
    md_valid = 1'b1; md_op = 3'b111;
    @(posedge clk); #1;
    md_op = 3'b000;
    chk("op111_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    md_valid = 1'b0; d_uses_md = 1'b0;
    chk("op000_busy", 32'(busy), 32'd0);
    chk("noop_hi", hi, 32'h12345678);
    chk("noop_lo", lo, 32'h9ABCDEF0);
    $display("txn no-ops hi=%h lo=%h busy=%0d", hi, lo, busy);

    // Reset during cycle 3 of a div aborts it with no commit
    @(posedge clk); #1;
    md_valid = 1'b1; md_op = 3'b011; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    md_valid = 1'b0; md_op = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0; d_uses_md = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1; d_uses_md = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_late_hi", hi, 32'd0);
    chk("abort_no_late_lo", lo, 32'd0);
    chk("abort_no_late_busy", 32'(busy), 32'd0);
    $display("txn reset-abort hi=%h lo=%h busy=%0d", hi, lo, busy);

    do_op("mult_after_reset", 3'b001, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 5);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide unit with its sequencing controller, in the E stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E and holds the HI/LO registers read by mfhi/mflo.
- Counts out the fixed operation latency.
- Raises the stall request the hazard unit uses to freeze D/F while a D-stage mult/div-class instruction would collide with the busy unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- md_op  in  3  E-stage op: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- md_valid  in  1  E-stage instruction is real (not a bubble/flushed slot).
- src_a  in  32  rs value (forwarded).
- src_b  in  32  rt value (forwarded).
- d_uses_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in progress.
- stall  out  1  stall request to hazard unit.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (reset_n=0, async): state IDLE, counter 0, busy=0, hi=0, lo=0, internal result registers 0. Reset mid-operation aborts it; no partial commit.
- start = md_valid & md_op in {001..100} & state==IDLE.
- States:
  - IDLE: on start at edge t0, latch the full result into pend_hi/pend_lo, load counter = N-1 (N = MULT_CYCLES or DIV_CYCLES), go to MUL or DIV.
  - MUL/DIV: decrement counter each edge; on the edge where counter==0, copy pend_hi/pend_lo to hi/lo and return to IDLE.
- busy = (state != IDLE), registered. Ops issued at edge t0: busy=1 during cycles t0+1..t0+N; hi/lo take the new value and busy falls at edge t0+N.
- stall = d_uses_md & (busy | start), combinational. Covers the issue cycle itself.
- mthi/mtlo: when md_valid and state==IDLE, write src_a to hi/lo at the next edge. busy is not asserted.
- Any md op presented while busy is ignored. The hazard unit guarantees this does not happen; the bench asserts it does not happen.
- mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0]. multu: unsigned.
- div: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. divu: unsigned.
- Divide by zero (src_b==0): op still takes DIV_CYCLES with busy=1, but hi/lo are left unchanged at completion.
- hi/lo never show intermediate values; mfhi/mflo read the old values until the commit edge.
- md_valid=0 or md_op none/111: no state change.

Test Plan:
- mult src_a=0xFFFFFFFD (-3), src_b=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall=1 on each of those cycles while d_uses_md=1.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div -7 / 2 -> 10 busy cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1. div 0x80000000 / -1 -> lo=0x80000000, hi=0.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge each, busy stays 0. Then divu x/0 -> busy 10 cycles, hi/lo unchanged afterward.
- Issue cycle with d_uses_md=1 -> stall=1 in the same cycle. Issue with d_uses_md=0 -> stall=0 throughout. After commit with d_uses_md=1 -> stall=0.
- Assert reset_n low at cycle 3 of a div -> immediately busy=0, hi=lo=0. After release, a new mult completes normally.
